// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: A - B - borrow_in, one bit per clock, LSB first,
// built from a single full-subtractor cell and a borrow flip-flop.

module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_subtractor #(
  parameter int WIDTH = 8  // legal range 2..32
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_bin,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_bout,
  output logic             out_busy,
  output logic             out_done
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr, r_sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d, nb;
  logic [WIDTH-1:0] r_next;

  full_subtractor u_fs (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .bin (br),
    .d   (d),
    .bout(nb)
  );

  // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  assign r_next = {d, r_sr[WIDTH-1:1]};

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      r_sr     <= '0;
      br       <= 1'b0;
      cnt      <= '0;
      out_diff <= '0;
      out_bout <= 1'b0;
      out_busy <= 1'b0;
      out_done <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          out_done <= 1'b0;
          if (in_start) begin
            a_sr     <= in_a;
            b_sr     <= in_b;
            br       <= in_bin;
            cnt      <= '0;
            out_busy <= 1'b1;
            state    <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          r_sr <= r_next;
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          br   <= nb;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            out_diff <= r_next;
            out_bout <= nb;
            out_busy <= 1'b0;
            out_done <= 1'b1;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed scenarios plus a random
// sweep checked against an integer-arithmetic reference.

module tb_serial_subtractor;
  localparam int W = 8;

  logic         in_clk = 1'b0;
  logic         in_rst_n = 1'b0;
  logic         in_start = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_bin = 1'b0;
  logic [W-1:0] out_diff;
  logic         out_bout;
  logic         out_busy;
  logic         out_done;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .in_clk  (in_clk),
    .in_rst_n(in_rst_n),
    .in_start(in_start),
    .in_a    (in_a),
    .in_b    (in_b),
    .in_bin  (in_bin),
    .out_diff(out_diff),
    .out_bout(out_bout),
    .out_busy(out_busy),
    .out_done(out_done)
  );

  always #5 in_clk = ~in_clk;

  // Reference: plain signed integer subtraction.
  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] a, b, input logic bin);
    int r;
    r = int'(a) - int'(b) - int'(bin);
    return W'(r & ((1 << W) - 1));
  endfunction

  function automatic logic ref_bout(input logic [W-1:0] a, b, input logic bin);
    return int'(a) < (int'(b) + int'(bin));
  endfunction

  // Present an operation at a falling edge, let the next rising edge take it,
  // then scramble the operand inputs since they must no longer matter.
  task automatic start_op(input logic [W-1:0] a, b, input logic bin);
    @(negedge in_clk);
    in_a = a; in_b = b; in_bin = bin; in_start = 1'b1;
    @(posedge in_clk);
    #1;
    in_start = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom); in_bin = 1'($urandom);
  endtask

  // Sample on falling edges until done; n counts samples including the done one.
  task automatic wait_done(output int n, output int busy_n, output bit timeout);
    n = 0; busy_n = 0; timeout = 1'b1;
    for (int i = 0; i < 4 * W; i++) begin
      @(negedge in_clk);
      n++;
      if (out_busy) busy_n++;
      if (out_done) begin timeout = 1'b0; break; end
    end
  endtask

  task automatic test_reset;
    in_rst_n = 1'b0;
    repeat (2) @(posedge in_clk);
    @(negedge in_clk);
    in_rst_n = 1'b1;
    checks++;
    if ({out_diff, out_bout, out_busy, out_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got diff=%h bout=%b busy=%b done=%b, want all 0",
               out_diff, out_bout, out_busy, out_done);
    end
    repeat (3) @(negedge in_clk);
    checks++;
    if (out_busy !== 1'b0 || out_done !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start: got busy=%b done=%b, want 0 0", out_busy, out_done);
    end
  endtask

  task automatic test_basic;
    logic [W-1:0] av [3] = '{8'h05, 8'h03, 8'h00};
    logic [W-1:0] bv [3] = '{8'h03, 8'h05, 8'h00};
    logic         cv [3] = '{1'b0, 1'b0, 1'b1};
    int n, bn; bit to;
    for (int i = 0; i < 3; i++) begin
      start_op(av[i], bv[i], cv[i]);
      wait_done(n, bn, to);
      checks++;
      if (to || n != W + 1 || bn != W) begin
        errors++;
        $display("FAIL basic_timing[%0d]: got timeout=%0b done_after=%0d busy_cycles=%0d, want 0 %0d %0d",
                 i, to, n, bn, W + 1, W);
      end
      checks++;
      if (out_diff !== ref_diff(av[i], bv[i], cv[i]) || out_bout !== ref_bout(av[i], bv[i], cv[i])) begin
        errors++;
        $display("FAIL basic_result[%0d]: got diff=%h bout=%b, want diff=%h bout=%b", i,
                 out_diff, out_bout, ref_diff(av[i], bv[i], cv[i]), ref_bout(av[i], bv[i], cv[i]));
      end
      checks++;
      if (out_busy !== 1'b0) begin
        errors++;
        $display("FAIL basic_busy_in_done[%0d]: got busy=%b, want 0", i, out_busy);
      end
    end
  endtask

  task automatic test_start_ignored;
    int n, bn, extra; bit to;
    start_op(8'h80, 8'h01, 1'b0);
    repeat (3) @(negedge in_clk);
    in_a = 8'hFF; in_b = 8'h00; in_start = 1'b1;
    @(negedge in_clk);
    in_start = 1'b0;
    wait_done(n, bn, to);
    checks++;
    if (to || out_diff !== 8'h7F || out_bout !== 1'b0) begin
      errors++;
      $display("FAIL start_ignored_result: got timeout=%0b diff=%h bout=%b, want 0 7f 0",
               to, out_diff, out_bout);
    end
    extra = 0;
    repeat (3 * W) begin
      @(negedge in_clk);
      if (out_done) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL start_ignored_single_done: got %0d extra done pulses, want 0", extra);
    end
  endtask

  task automatic test_back_to_back;
    int n, bn, moved; bit to;
    start_op(8'h80, 8'h01, 1'b0);
    wait_done(n, bn, to);
    checks++;
    if (to || out_diff !== 8'h7F) begin
      errors++;
      $display("FAIL b2b_first: got timeout=%0b diff=%h, want 0 7f", to, out_diff);
    end
    // Still in the done cycle: request the next operation right now.
    in_a = 8'hFF; in_b = 8'hFF; in_bin = 1'b0; in_start = 1'b1;
    @(posedge in_clk);
    #1;
    in_start = 1'b0; in_a = 8'h12; in_b = 8'h34; in_bin = 1'b1;
    @(negedge in_clk);
    checks++;
    if (out_busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_no_bubble: got busy=%b, want 1", out_busy);
    end
    moved = 0;
    n = 0; to = 1'b1;
    for (int i = 0; i < 4 * W; i++) begin
      if (out_done) begin to = 1'b0; break; end
      if (out_diff !== 8'h7F || out_bout !== 1'b0) moved++;
      @(negedge in_clk);
      n++;
    end
    checks++;
    if (moved != 0) begin
      errors++;
      $display("FAIL b2b_result_hold: got %0d cycles with changed result, want 0", moved);
    end
    checks++;
    if (to || n != W || out_diff !== 8'h00 || out_bout !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: got timeout=%0b cycles=%0d diff=%h bout=%b, want 0 %0d 00 0",
               to, n, out_diff, out_bout, W);
    end
  endtask

  task automatic test_reset_mid;
    int n, bn, extra; bit to;
    start_op(8'hA5, 8'h3C, 1'b1);
    repeat (4) @(negedge in_clk);
    in_rst_n = 1'b0;
    @(posedge in_clk);
    #1;
    in_rst_n = 1'b1;
    @(negedge in_clk);
    checks++;
    if ({out_diff, out_bout, out_busy, out_done} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got diff=%h bout=%b busy=%b done=%b, want all 0",
               out_diff, out_bout, out_busy, out_done);
    end
    extra = 0;
    repeat (3 * W) begin
      @(negedge in_clk);
      if (out_done || out_busy) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL reset_mid_abandon: got %0d busy/done cycles after reset, want 0", extra);
    end
    start_op(8'h10, 8'h20, 1'b0);
    wait_done(n, bn, to);
    checks++;
    if (to || out_diff !== ref_diff(8'h10, 8'h20, 1'b0) || out_bout !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_fresh: got timeout=%0b diff=%h bout=%b, want 0 %h 1",
               to, out_diff, out_bout, ref_diff(8'h10, 8'h20, 1'b0));
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b; logic c;
    int n, bn; bit to;
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom); b = W'($urandom); c = 1'($urandom);
      if (i < 4) begin a = (i[0]) ? '1 : '0; b = (i[1]) ? '1 : '0; end
      start_op(a, b, c);
      wait_done(n, bn, to);
      checks++;
      if (to) begin
        errors++;
        $display("FAIL random_timeout[%0d]: no done within %0d cycles", i, 4 * W);
      end
      checks++;
      if (out_diff !== ref_diff(a, b, c) || out_bout !== ref_bout(a, b, c)) begin
        errors++;
        $display("FAIL random_result[%0d] a=%h b=%h bin=%b: got diff=%h bout=%b, want diff=%h bout=%b",
                 i, a, b, c, out_diff, out_bout, ref_diff(a, b, c), ref_bout(a, b, c));
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_start_ignored;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
